total_zeros_encoding: RTL and testbench



---
 rtl/total_zeros_encoding_pkg.sv | 32 +++
 rtl/total_zeros_vlc_lut.sv | 85 ++++++++
 rtl/total_zeros_encoding.sv | 119 +++++++++++
 tb/tb_total_zeros_encoding.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/total_zeros_encoding_pkg.sv
// Shared residual block type codes, FSM state type and the maxNumCoeff
// selection rule used by the total_zeros encoder.
package total_zeros_encoding_pkg;

    localparam logic [3:0] RS_INTRA16_DC   = 4'd1;
    localparam logic [3:0] RS_INTRA16_AC   = 4'd2;
    localparam logic [3:0] RS_LUMA         = 4'd4;
    localparam logic [3:0] RS_CHROMA_DC_CB = 4'd6;
    localparam logic [3:0] RS_CHROMA_DC_CR = 4'd7;
    localparam logic [3:0] RS_CHROMA_AC_CB = 4'd8;
    localparam logic [3:0] RS_CHROMA_AC_CR = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LUT  = 2'd1,
        ST_OUT  = 2'd2
    } tz_state_e;

    // Block types that carry no coefficient count keep the previous value.
    function automatic logic [4:0] max_coeff_for(input logic [3:0] rs, input logic [4:0] prev);
        logic [4:0] m;
        m = prev;
        case (rs)
            RS_INTRA16_DC, RS_LUMA:                         m = 5'd16;
            RS_INTRA16_AC, RS_CHROMA_AC_CB, RS_CHROMA_AC_CR: m = 5'd15;
            RS_CHROMA_DC_CB, RS_CHROMA_DC_CR:               m = 5'd4;
            default:                                        m = prev;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/total_zeros_vlc_lut.sv
// Combinational total_zeros codeword table: 4x4 and 8x8 blocks share one table,
// 2x2 chroma DC has its own. Codewords are right-aligned, unused pairs give 0/0.
module total_zeros_vlc_lut (
    input  logic [3:0] i_total_coeff,
    input  logic [3:0] i_total_zeros,
    input  logic       i_chroma_dc,
    output logic [8:0] o_code_bits,
    output logic [3:0] o_code_len
);
    logic [7:0]  w_key;
    logic [12:0] w_cw;

    // Key is {TotalCoeff, total_zeros} so each hex label reads as "tc, tz".
    assign w_key = {i_total_coeff, i_total_zeros};

    always_comb begin
        w_cw = '0;
        if (i_chroma_dc) begin
            case (w_key)
                8'h10: w_cw = {4'd1, 9'b1};   8'h11: w_cw = {4'd2, 9'b01};  8'h12: w_cw = {4'd3, 9'b001};
                8'h13: w_cw = {4'd3, 9'b000}; 8'h20: w_cw = {4'd1, 9'b1};   8'h21: w_cw = {4'd2, 9'b01};
                8'h22: w_cw = {4'd2, 9'b00};  8'h30: w_cw = {4'd1, 9'b1};   8'h31: w_cw = {4'd1, 9'b0};
                default: w_cw = '0;
            endcase
        end else begin
            case (w_key)
                8'h10: w_cw = {4'd1, 9'b1};         8'h11: w_cw = {4'd3, 9'b011};       8'h12: w_cw = {4'd3, 9'b010};
                8'h13: w_cw = {4'd4, 9'b0011};      8'h14: w_cw = {4'd4, 9'b0010};      8'h15: w_cw = {4'd5, 9'b00011};
                8'h16: w_cw = {4'd5, 9'b00010};     8'h17: w_cw = {4'd6, 9'b000011};    8'h18: w_cw = {4'd6, 9'b000010};
                8'h19: w_cw = {4'd7, 9'b0000011};   8'h1A: w_cw = {4'd7, 9'b0000010};   8'h1B: w_cw = {4'd8, 9'b00000011};
                8'h1C: w_cw = {4'd8, 9'b00000010};  8'h1D: w_cw = {4'd9, 9'b000000011}; 8'h1E: w_cw = {4'd9, 9'b000000010};
                8'h1F: w_cw = {4'd9, 9'b000000001};
                8'h20: w_cw = {4'd3, 9'b111};       8'h21: w_cw = {4'd3, 9'b110};       8'h22: w_cw = {4'd3, 9'b101};
                8'h23: w_cw = {4'd3, 9'b100};       8'h24: w_cw = {4'd3, 9'b011};       8'h25: w_cw = {4'd4, 9'b0101};
                8'h26: w_cw = {4'd4, 9'b0100};      8'h27: w_cw = {4'd4, 9'b0011};      8'h28: w_cw = {4'd4, 9'b0010};
                8'h29: w_cw = {4'd5, 9'b00011};     8'h2A: w_cw = {4'd5, 9'b00010};     8'h2B: w_cw = {4'd6, 9'b000011};
                8'h2C: w_cw = {4'd6, 9'b000010};    8'h2D: w_cw = {4'd6, 9'b000001};    8'h2E: w_cw = {4'd6, 9'b000000};
                8'h30: w_cw = {4'd4, 9'b0101};      8'h31: w_cw = {4'd3, 9'b111};       8'h32: w_cw = {4'd3, 9'b110};
                8'h33: w_cw = {4'd3, 9'b101};       8'h34: w_cw = {4'd4, 9'b0100};      8'h35: w_cw = {4'd4, 9'b0011};
                8'h36: w_cw = {4'd3, 9'b100};       8'h37: w_cw = {4'd3, 9'b011};       8'h38: w_cw = {4'd4, 9'b0010};
                8'h39: w_cw = {4'd5, 9'b00011};     8'h3A: w_cw = {4'd5, 9'b00010};     8'h3B: w_cw = {4'd6, 9'b000001};
                8'h3C: w_cw = {4'd5, 9'b00001};     8'h3D: w_cw = {4'd6, 9'b000000};
                8'h40: w_cw = {4'd5, 9'b00011};     8'h41: w_cw = {4'd3, 9'b111};       8'h42: w_cw = {4'd4, 9'b0101};
                8'h43: w_cw = {4'd4, 9'b0100};      8'h44: w_cw = {4'd3, 9'b110};       8'h45: w_cw = {4'd3, 9'b101};
                8'h46: w_cw = {4'd3, 9'b100};       8'h47: w_cw = {4'd4, 9'b0011};      8'h48: w_cw = {4'd3, 9'b011};
                8'h49: w_cw = {4'd4, 9'b0010};      8'h4A: w_cw = {4'd5, 9'b00010};     8'h4B: w_cw = {4'd5, 9'b00001};
                8'h4C: w_cw = {4'd5, 9'b00000};
                8'h50: w_cw = {4'd4, 9'b0101};      8'h51: w_cw = {4'd4, 9'b0100};      8'h52: w_cw = {4'd4, 9'b0011};
                8'h53: w_cw = {4'd3, 9'b111};       8'h54: w_cw = {4'd3, 9'b110};       8'h55: w_cw = {4'd3, 9'b101};
                8'h56: w_cw = {4'd3, 9'b100};       8'h57: w_cw = {4'd3, 9'b011};       8'h58: w_cw = {4'd4, 9'b0010};
                8'h59: w_cw = {4'd5, 9'b00001};     8'h5A: w_cw = {4'd4, 9'b0001};      8'h5B: w_cw = {4'd5, 9'b00000};
                8'h60: w_cw = {4'd6, 9'b000001};    8'h61: w_cw = {4'd5, 9'b00001};     8'h62: w_cw = {4'd3, 9'b111};
                8'h63: w_cw = {4'd3, 9'b110};       8'h64: w_cw = {4'd3, 9'b101};       8'h65: w_cw = {4'd3, 9'b100};
                8'h66: w_cw = {4'd3, 9'b011};       8'h67: w_cw = {4'd3, 9'b010};       8'h68: w_cw = {4'd4, 9'b0001};
                8'h69: w_cw = {4'd3, 9'b001};       8'h6A: w_cw = {4'd6, 9'b000000};
                8'h70: w_cw = {4'd6, 9'b000001};    8'h71: w_cw = {4'd5, 9'b00001};     8'h72: w_cw = {4'd3, 9'b101};
                8'h73: w_cw = {4'd3, 9'b100};       8'h74: w_cw = {4'd3, 9'b011};       8'h75: w_cw = {4'd2, 9'b11};
                8'h76: w_cw = {4'd3, 9'b010};       8'h77: w_cw = {4'd4, 9'b0001};      8'h78: w_cw = {4'd3, 9'b001};
                8'h79: w_cw = {4'd6, 9'b000000};
                8'h80: w_cw = {4'd6, 9'b000001};    8'h81: w_cw = {4'd4, 9'b0001};      8'h82: w_cw = {4'd5, 9'b00001};
                8'h83: w_cw = {4'd3, 9'b011};       8'h84: w_cw = {4'd2, 9'b11};        8'h85: w_cw = {4'd2, 9'b10};
                8'h86: w_cw = {4'd3, 9'b010};       8'h87: w_cw = {4'd3, 9'b001};       8'h88: w_cw = {4'd6, 9'b000000};
                8'h90: w_cw = {4'd6, 9'b000001};    8'h91: w_cw = {4'd6, 9'b000000};    8'h92: w_cw = {4'd4, 9'b0001};
                8'h93: w_cw = {4'd2, 9'b11};        8'h94: w_cw = {4'd2, 9'b10};        8'h95: w_cw = {4'd3, 9'b001};
                8'h96: w_cw = {4'd2, 9'b01};        8'h97: w_cw = {4'd5, 9'b00001};
                8'hA0: w_cw = {4'd5, 9'b00001};     8'hA1: w_cw = {4'd5, 9'b00000};     8'hA2: w_cw = {4'd3, 9'b001};
                8'hA3: w_cw = {4'd2, 9'b11};        8'hA4: w_cw = {4'd2, 9'b10};        8'hA5: w_cw = {4'd2, 9'b01};
                8'hA6: w_cw = {4'd4, 9'b0001};
                8'hB0: w_cw = {4'd4, 9'b0000};      8'hB1: w_cw = {4'd4, 9'b0001};      8'hB2: w_cw = {4'd3, 9'b001};
                8'hB3: w_cw = {4'd3, 9'b010};       8'hB4: w_cw = {4'd1, 9'b1};         8'hB5: w_cw = {4'd3, 9'b011};
                8'hC0: w_cw = {4'd4, 9'b0000};      8'hC1: w_cw = {4'd4, 9'b0001};      8'hC2: w_cw = {4'd2, 9'b01};
                8'hC3: w_cw = {4'd1, 9'b1};         8'hC4: w_cw = {4'd3, 9'b001};
                8'hD0: w_cw = {4'd3, 9'b000};       8'hD1: w_cw = {4'd3, 9'b001};       8'hD2: w_cw = {4'd1, 9'b1};
                8'hD3: w_cw = {4'd2, 9'b01};
                8'hE0: w_cw = {4'd2, 9'b00};        8'hE1: w_cw = {4'd2, 9'b01};        8'hE2: w_cw = {4'd1, 9'b1};
                8'hF0: w_cw = {4'd1, 9'b0};         8'hF1: w_cw = {4'd1, 9'b1};
                default: w_cw = '0;
            endcase
        end
    end

    assign o_code_len  = w_cw[12:9];
    assign o_code_bits = w_cw[8:0];

endmodule

// File: rtl/total_zeros_encoding.sv
// CAVLC total_zeros encoder: captures one block, looks up its VLC and hands the
// codeword to the bitstream writer over a valid/ready handshake.
module total_zeros_encoding
    import total_zeros_encoding_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] residual_state,
    input  logic       start,
    input  logic [4:0] TotalCoeff,
    input  logic [3:0] total_zeros_in,
    output logic       idle,
    output logic       code_valid,
    input  logic       code_ready,
    output logic [8:0] code_bits,
    output logic [3:0] code_len,
    output logic       done,
    output logic       tz_error
);
    tz_state_e  r_state;
    logic [4:0] r_max_coeff;
    logic [4:0] r_max_cap;
    logic [4:0] r_tc;
    logic [3:0] r_tz;
    logic       r_idle;
    logic       r_code_valid;
    logic [8:0] r_code_bits;
    logic [3:0] r_code_len;
    logic       r_done;
    logic       r_tz_error;

    logic [8:0] w_lut_bits;
    logic [3:0] w_lut_len;
    logic       w_skip;
    logic       w_illegal;

    always_ff @(posedge clk) begin
        if (!reset_n) r_max_coeff <= 5'd0;
        else          r_max_coeff <= max_coeff_for(residual_state, r_max_coeff);
    end

    // Subtraction is only consulted when not skipping, so r_max_cap > r_tc there.
    assign w_skip    = (r_tc == 5'd0) || (r_tc >= r_max_cap);
    assign w_illegal = ({1'b0, r_tz} > (r_max_cap - r_tc));

    total_zeros_vlc_lut u_lut (
        .i_total_coeff (r_tc[3:0]),
        .i_total_zeros (r_tz),
        .i_chroma_dc   (r_max_cap == 5'd4),
        .o_code_bits   (w_lut_bits),
        .o_code_len    (w_lut_len)
    );

    // Handshake: code_valid is raised only in OUT; the codeword transfers on a
    // cycle with code_valid & code_ready and bits/len stay frozen until then.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_idle       <= 1'b1;
            r_code_valid <= 1'b0;
            r_code_bits  <= 9'd0;
            r_code_len   <= 4'd0;
            r_done       <= 1'b0;
            r_tz_error   <= 1'b0;
            r_max_cap    <= 5'd0;
            r_tc         <= 5'd0;
            r_tz         <= 4'd0;
        end else begin
            r_done     <= 1'b0;
            r_tz_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_tc      <= TotalCoeff;
                        r_tz      <= total_zeros_in;
                        r_max_cap <= r_max_coeff;
                        r_idle    <= 1'b0;
                        r_state   <= ST_LUT;
                    end
                end
                ST_LUT: begin
                    if (w_skip || w_illegal) begin
                        r_done     <= 1'b1;
                        r_tz_error <= !w_skip;
                        r_idle     <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_code_bits  <= w_lut_bits;
                        r_code_len   <= w_lut_len;
                        r_code_valid <= 1'b1;
                        r_state      <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (code_ready) begin
                        r_code_valid <= 1'b0;
                        r_code_bits  <= 9'd0;
                        r_code_len   <= 4'd0;
                        r_done       <= 1'b1;
                        r_idle       <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_idle  <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign idle       = r_idle;
    assign code_valid = r_code_valid;
    assign code_bits  = r_code_bits;
    assign code_len   = r_code_len;
    assign done       = r_done;
    assign tz_error   = r_tz_error;

endmodule

// File: tb/tb_total_zeros_encoding.sv
// Self-checking bench for total_zeros_encoding; reference codewords come from
// the standard's table columns written as codeword strings.
module tb_total_zeros_encoding;
    import total_zeros_encoding_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] residual_state;
    logic       start;
    logic [4:0] TotalCoeff;
    logic [3:0] total_zeros_in;
    logic       idle;
    logic       code_valid;
    logic       code_ready;
    logic [8:0] code_bits;
    logic [3:0] code_len;
    logic       done;
    logic       tz_error;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         mdl_max  = 0;
    logic [3:0] rs_cur   = 4'd0;

    always #5 clk = ~clk;

    total_zeros_encoding dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .residual_state (residual_state),
        .start          (start),
        .TotalCoeff     (TotalCoeff),
        .total_zeros_in (total_zeros_in),
        .idle           (idle),
        .code_valid     (code_valid),
        .code_ready     (code_ready),
        .code_bits      (code_bits),
        .code_len       (code_len),
        .done           (done),
        .tz_error       (tz_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bench_max(input logic [3:0] rs, input int prev);
        if (rs == RS_INTRA16_DC || rs == RS_LUMA) return 16;
        if (rs == RS_INTRA16_AC || rs == RS_CHROMA_AC_CB || rs == RS_CHROMA_AC_CR) return 15;
        if (rs == RS_CHROMA_DC_CB || rs == RS_CHROMA_DC_CR) return 4;
        return prev;
    endfunction

    // One table column per TotalCoeff, codewords listed in total_zeros order.
    function automatic string column(input int mx, input int tc);
        string s;
        s = "";
        if (mx == 4) begin
            case (tc)
                1: s = "1 01 001 000";
                2: s = "1 01 00";
                3: s = "1 0";
                default: s = "";
            endcase
        end else begin
            case (tc)
                1:  s = "1 011 010 0011 0010 00011 00010 000011 000010 0000011 0000010 00000011 00000010 000000011 000000010 000000001";
                2:  s = "111 110 101 100 011 0101 0100 0011 0010 00011 00010 000011 000010 000001 000000";
                3:  s = "0101 111 110 101 0100 0011 100 011 0010 00011 00010 000001 00001 000000";
                4:  s = "00011 111 0101 0100 110 101 100 0011 011 0010 00010 00001 00000";
                5:  s = "0101 0100 0011 111 110 101 100 011 0010 00001 0001 00000";
                6:  s = "000001 00001 111 110 101 100 011 010 0001 001 000000";
                7:  s = "000001 00001 101 100 011 11 010 0001 001 000000";
                8:  s = "000001 0001 00001 011 11 10 010 001 000000";
                9:  s = "000001 000000 0001 11 10 001 01 00001";
                10: s = "00001 00000 001 11 10 01 0001";
                11: s = "0000 0001 001 010 1 011";
                12: s = "0000 0001 01 1 001";
                13: s = "000 001 1 01";
                14: s = "00 01 1";
                15: s = "0 1";
                default: s = "";
            endcase
        end
        return s;
    endfunction

    function automatic string nth_token(input string s, input int n);
        int k;
        int first;
        k = 0;
        first = 0;
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s.getc(i) == " ") begin
                if (k == n) return s.substr(first, i - 1);
                k++;
                first = i + 1;
            end
        end
        return "";
    endfunction

    function automatic logic [15:0] str_bits(input string tok);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < tok.len(); i++) v = {v[14:0], (tok.getc(i) == "1")};
        return v;
    endfunction

    task automatic model(input int mx, input int tc, input int tz, output bit skip, output bit ill,
                         output logic [8:0] eb, output logic [3:0] el);
        string tok;
        logic [15:0] v;
        skip = (tc == 0) || (tc >= mx);
        ill  = !skip && (tz > mx - tc);
        eb = '0;
        el = '0;
        if (!skip && !ill) begin
            tok = nth_token(column(mx, tc), tz);
            v   = str_bits(tok);
            eb  = v[8:0];
            el  = 4'(tok.len());
        end
    endtask

    task automatic set_rs(input logic [3:0] rs);
        residual_state = rs;
        rs_cur = rs;
        tick();
        mdl_max = bench_max(rs, mdl_max);
    endtask

    task automatic run_block(input int tc, input int tz, input int rdly, input bit junk,
                             output logic [8:0] b, output logic [3:0] l);
        bit skip, ill;
        logic [8:0] eb;
        logic [3:0] el;
        model(mdl_max, tc, tz, skip, ill, eb, el);
        b = '0;
        l = '0;
        check("idle_pre", 32'(idle), 1);
        TotalCoeff = 5'(tc);
        total_zeros_in = 4'(tz);
        start = 1'b1;
        tick();
        if (junk) begin
            TotalCoeff = 5'($urandom_range(0, 16));
            total_zeros_in = 4'($urandom_range(0, 15));
        end else begin
            start = 1'b0;
        end
        check("lut_idle", 32'(idle), 0);
        check("lut_valid", 32'(code_valid), 0);
        check("lut_done", 32'(done), 0);
        tick();
        if (skip || ill) begin
            start = 1'b0;
            check("skip_done", 32'(done), 1);
            check("skip_tzerr", 32'(tz_error), 32'(ill));
            check("skip_valid", 32'(code_valid), 0);
            check("skip_len", 32'(code_len), 0);
            check("skip_idle", 32'(idle), 1);
        end else begin
            check("cw_valid", 32'(code_valid), 1);
            check("cw_bits", 32'(code_bits), 32'(eb));
            check("cw_len", 32'(code_len), 32'(el));
            check("cw_done", 32'(done), 0);
            b = code_bits;
            l = code_len;
            for (int i = 0; i < rdly; i++) begin
                tick();
                check("hold_valid", 32'(code_valid), 1);
                check("hold_bits", 32'(code_bits), 32'(eb));
                check("hold_len", 32'(code_len), 32'(el));
                check("hold_done", 32'(done), 0);
            end
            code_ready = 1'b1;
            tick();
            code_ready = 1'b0;
            start = 1'b0;
            check("hs_done", 32'(done), 1);
            check("hs_tzerr", 32'(tz_error), 0);
            check("hs_valid", 32'(code_valid), 0);
            check("hs_len", 32'(code_len), 0);
            check("hs_bits", 32'(code_bits), 0);
            check("hs_idle", 32'(idle), 1);
        end
    endtask

    // Left-align the emitted codeword and prefix-decode it against the table column.
    task automatic loopback(input int mx, input int tc, input int tz, input logic [8:0] b, input logic [3:0] l);
        logic [15:0] w;
        string col;
        string tok;
        int got_tz;
        int got_len;
        w = 16'(b) << (16 - int'(l));
        col = column(mx, tc);
        got_tz = -1;
        got_len = 0;
        for (int t = 0; t < 16; t++) begin
            tok = nth_token(col, t);
            if (got_tz < 0 && tok.len() > 0 && (w >> (16 - tok.len())) == str_bits(tok)) begin
                got_tz = t;
                got_len = tok.len();
            end
        end
        check("loop_tz", 32'(got_tz), 32'(tz));
        check("loop_len", 32'(got_len), 32'(l));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] b;
        logic [3:0] l;
        logic [3:0] ex_rs [3];
        reset_n = 1'b0;
        residual_state = 4'd0;
        start = 1'b0;
        TotalCoeff = '0;
        total_zeros_in = '0;
        code_ready = 1'b0;
        tick();
        tick();
        check("rst_idle", 32'(idle), 1);
        check("rst_valid", 32'(code_valid), 0);
        check("rst_bits", 32'(code_bits), 0);
        check("rst_len", 32'(code_len), 0);
        check("rst_done", 32'(done), 0);
        check("rst_tzerr", 32'(tz_error), 0);
        reset_n = 1'b1;
        set_rs(4'd0);

        // maxNumCoeff still 0 after reset: any block is skipped
        run_block(1, 0, 0, 0, b, l);

        set_rs(RS_LUMA);
        run_block(1, 0, 0, 0, b, l);
        run_block(1, 15, 0, 0, b, l);
        run_block(2, 0, 0, 0, b, l);
        run_block(15, 1, 5, 0, b, l);
        run_block(16, 0, 0, 0, b, l);
        run_block(0, 3, 0, 0, b, l);
        run_block(1, 15, 2, 1, b, l);

        set_rs(RS_CHROMA_DC_CB);
        run_block(1, 3, 0, 0, b, l);
        run_block(3, 1, 0, 0, b, l);
        run_block(2, 2, 0, 0, b, l);
        run_block(2, 3, 0, 0, b, l);
        run_block(4, 0, 0, 0, b, l);
        set_rs(4'd15);
        run_block(1, 3, 1, 0, b, l);

        set_rs(RS_CHROMA_AC_CR);
        run_block(1, 15, 0, 0, b, l);
        run_block(14, 1, 0, 1, b, l);
        run_block(15, 0, 0, 0, b, l);

        // Reset while a codeword is waiting aborts the block without done
        set_rs(RS_LUMA);
        TotalCoeff = 5'd3;
        total_zeros_in = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_pre_valid", 32'(code_valid), 1);
        reset_n = 1'b0;
        tick();
        check("abort_valid", 32'(code_valid), 0);
        check("abort_idle", 32'(idle), 1);
        check("abort_done", 32'(done), 0);
        check("abort_len", 32'(code_len), 0);
        check("abort_bits", 32'(code_bits), 0);
        reset_n = 1'b1;
        mdl_max = 0;
        set_rs(rs_cur);
        check("abort_post_done", 32'(done), 0);
        check("abort_post_idle", 32'(idle), 1);

        ex_rs[0] = RS_LUMA;
        ex_rs[1] = RS_INTRA16_AC;
        ex_rs[2] = RS_CHROMA_DC_CR;
        for (int r = 0; r < 3; r++) begin
            set_rs(ex_rs[r]);
            for (int tc = 1; tc < mdl_max; tc++) begin
                for (int tz = 0; tz <= mdl_max - tc; tz++) begin
                    run_block(tc, tz, 0, 0, b, l);
                    loopback(mdl_max, tc, tz, b, l);
                end
            end
        end

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) set_rs(4'($urandom_range(0, 15)));
            run_block($urandom_range(0, 16), $urandom_range(0, 15), $urandom_range(0, 3),
                      bit'($urandom_range(0, 1)), b, l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
